data_bus_router: RTL and testbench
==================================

DATA_BUS_ROUTER -- requirements
Module: data_bus_router

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 3: number of mapped data-bus regions (legal range 1..8).
REQ-002 SHALL have parameter SEL_LSB, default 9: lowest address bit of the region-select field.
REQ-003 SHALL have parameter SEL_W, default 2: width of the region-select field; 2**SEL_W >= NUM_SLAVES.
REQ-004 SHALL have parameter DATA_W, default 32: data width.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum WAIT cycles before an error response (legal range 1..255).
REQ-006 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-007 clk_i  input  1  clock; all state changes on the rising edge.
REQ-008 rst_ni  input  1  asynchronous active-low reset.
REQ-009 req_i  input  1  master request; held high with addr_i/write_i stable until ready_o is seen.
REQ-010 addr_i  input  32  master byte address.
REQ-011 write_i  input  1  1 = write, 0 = read.
REQ-012 ready_o  output  1  one-cycle transaction completion.
REQ-013 rdata_o  output  DATA_W  read data; valid when ready_o=1.
REQ-014 err_o  output  1  error flag; valid when ready_o=1.
REQ-015 sel_o  output  NUM_SLAVES  one-hot slave select.
REQ-016 we_o  output  1  latched write_i; qualifies sel_o.
REQ-017 slave_rdata_i  input  NUM_SLAVES*DATA_W  packed slave read data; slave k occupies bits [k*DATA_W +: DATA_W].
REQ-018 slave_ready_i  input  NUM_SLAVES  per-slave completion; slave k may hold it high for one or more cycles.

Function
REQ-019 The region index SHALL be addr_i[SEL_LSB+SEL_W-1:SEL_LSB]; index < NUM_SLAVES is mapped, any other index is unmapped.
REQ-020 The FSM SHALL have three states, IDLE, WAIT and RESP, and SHALL reset to IDLE.
REQ-021 IDLE with req_i=1 and a mapped index: latch the index and write_i, clear the timeout counter, go to WAIT.
REQ-022 IDLE with req_i=1 and an unmapped index: go directly to RESP with the error flag set; no sel_o bit asserts.
REQ-023 IDLE with req_i=0: remain in IDLE.
REQ-024 In WAIT, sel_o SHALL be registered one-hot of the latched index and we_o SHALL equal the latched write_i; both SHALL be 0 in IDLE and RESP.
REQ-025 WAIT with slave_ready_i[idx]=1: for reads capture slave_rdata_i of slave idx into rdata_o; go to RESP with error clear.
REQ-026 WAIT with slave_ready_i[idx]=0: increment the counter; when the counter reaches TIMEOUT_CYCLES, go to RESP with err set and rdata_o=0.
REQ-027 If ready and timeout occur in the same cycle, ready SHALL win (no error).
REQ-028 slave_ready_i bits of non-selected slaves SHALL be ignored.
REQ-029 RESP: ready_o=1 and err_o reflects the error flag, for exactly one cycle; then go unconditionally to IDLE.
REQ-030 ready_o and err_o SHALL be 0 outside RESP.
REQ-031 rdata_o SHALL hold its last captured value until the next capture. Writes and unmapped accesses leave it unchanged, except that a timeout clears it to 0.
REQ-032 Latency: a mapped access whose slave is ready in its first WAIT cycle gives ready_o 2 cycles after req_i is sampled. An unmapped access gives ready_o after 1 cycle. A timeout gives ready_o after TIMEOUT_CYCLES+1 cycles.
REQ-033 A req_i still high in the RESP cycle belongs to the completing transaction. req_i high in the following IDLE cycle SHALL start a new transaction (back-to-back, one idle cycle minimum).
REQ-034 req_i dropping while in WAIT is a protocol violation; the block SHALL ignore it and complete normally.
REQ-035 The counter width SHALL be $clog2(TIMEOUT_CYCLES+1) and SHALL never wrap.

Reset
REQ-036 rst_ni=0 SHALL immediately force state=IDLE, counter=0, sel_o=0, we_o=0, ready_o=0, err_o=0, rdata_o=0, regardless of the clock.
REQ-037 A reset during WAIT SHALL abort the transaction with no ready_o; the first request after rst_ni rises SHALL be handled normally.

Verification (NUM_SLAVES=3, SEL_LSB=9, SEL_W=2, TIMEOUT_CYCLES=8)
REQ-038 Read addr 0x400, slave 2 ready in its first WAIT cycle with data 0xCAFEF00D -> sel_o=3'b100 for 1 cycle; ready_o=1, rdata_o=0xCAFEF00D, err_o=0 at cycle +2.
REQ-039 Write addr 0x000, slave 0 ready after 3 WAIT cycles -> we_o=1 and sel_o=3'b001 for 3 cycles; ready_o=1, err_o=0; rdata_o unchanged.
REQ-040 Read addr 0x600 (index 3, unmapped) -> sel_o stays 0; ready_o=1, err_o=1 at cycle +1.
REQ-041 Read addr 0x200, slave 1 never ready, slave 0 ready held high -> after 8 WAIT cycles ready_o=1, err_o=1, rdata_o=0.
REQ-042 Slave 1 ready on exactly the 8th WAIT cycle -> ready_o=1, err_o=0, data captured.
REQ-043 rst_ni pulsed low mid-WAIT -> all outputs 0 asynchronously, no ready_o; the next read completes normally.

Source files
------------

// File: rtl/data_bus_router_if.sv
// Bus bundle between a single master, the router and its mapped slaves.
// The master modport is the environment view; the slave modport is the router view.
interface data_bus_router_if #(
  parameter int NUM_SLAVES = 3,
  parameter int DATA_W     = 32
);
  logic                         req_i;
  logic [31:0]                  addr_i;
  logic                         write_i;
  logic                         ready_o;
  logic [DATA_W-1:0]            rdata_o;
  logic                         err_o;
  logic [NUM_SLAVES-1:0]        sel_o;
  logic                         we_o;
  logic [NUM_SLAVES*DATA_W-1:0] slave_rdata_i;
  logic [NUM_SLAVES-1:0]        slave_ready_i;

  modport master (
    output req_i, addr_i, write_i, slave_rdata_i, slave_ready_i,
    input  ready_o, rdata_o, err_o, sel_o, we_o
  );

  modport slave (
    input  req_i, addr_i, write_i, slave_rdata_i, slave_ready_i,
    output ready_o, rdata_o, err_o, sel_o, we_o
  );
endinterface

// File: rtl/data_bus_router.sv
// Address-decoded router from one master to NUM_SLAVES data-bus regions,
// with a per-access WAIT timeout that returns an error response.
module data_bus_router #(
  parameter int NUM_SLAVES     = 3,
  parameter int SEL_LSB        = 9,
  parameter int SEL_W          = 2,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               clk_i,
  input logic               rst_ni,
  data_bus_router_if.slave  bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic                  we_q, we_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic [SEL_W-1:0]      region;
  logic                  mapped;
  logic [NUM_SLAVES-1:0] region_onehot;
  logic                  slv_ready;
  logic [DATA_W-1:0]     slv_rdata;

  // sel_q is one-hot while in WAIT, so masking with it ignores other slaves
  always_comb begin
    region        = bus.addr_i[SEL_LSB +: SEL_W];
    mapped        = 32'(region) < 32'(NUM_SLAVES);
    region_onehot = '0;
    slv_rdata     = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      region_onehot[k] = (32'(region) == k);
      slv_rdata        = slv_rdata |
                         ({DATA_W{sel_q[k]}} & bus.slave_rdata_i[k*DATA_W +: DATA_W]);
    end
    slv_ready = |(sel_q & bus.slave_ready_i);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    we_d    = we_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          if (mapped) begin
            sel_d   = region_onehot;
            we_d    = bus.write_i;
            cnt_d   = '0;
            state_d = WAIT;
          end else begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (slv_ready) begin
          if (!we_q) rdata_d = slv_rdata;
          sel_d   = '0;
          we_d    = 1'b0;
          ready_d = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // this cycle is the last allowed WAIT cycle; counter lands on TIMEOUT_CYCLES
          cnt_d   = cnt_q + CNT_W'(1);
          sel_d   = '0;
          we_d    = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.sel_o   = sel_q;
  assign bus.we_o    = we_q;
  assign bus.ready_o = ready_q;
  assign bus.err_o   = err_q;
  assign bus.rdata_o = rdata_q;
endmodule

// File: tb/tb_data_bus_router.sv
// Directed and randomized bench for data_bus_router; expected responses come
// from a transaction-level model of the address map, latency and timeout rules.
module tb_data_bus_router;
  localparam int NS      = 3;
  localparam int SEL_LSB = 9;
  localparam int SEL_W   = 2;
  localparam int DW      = 32;
  localparam int TMO     = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [DW-1:0] exp_rdata;

  data_bus_router_if #(.NUM_SLAVES(NS), .DATA_W(DW)) bus ();

  data_bus_router #(
    .NUM_SLAVES(NS), .SEL_LSB(SEL_LSB), .SEL_W(SEL_W),
    .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NS-1:0] others(input int idx, input bit hold, input bit sel_rdy);
    logic [NS-1:0] v;
    v = hold ? '1 : NS'($urandom);
    if (idx < NS) v[idx] = sel_rdy;
    return v;
  endfunction

  // delay = WAIT cycle (1-based) on which the selected slave reports ready; > TMO means never
  task automatic run_txn(input logic [31:0] addr, input bit wr, input int delay,
                         input logic [DW-1:0] data, input bit hold_others, input bit drop_req);
    int idx;
    bit mapped;
    int lat;
    bit exp_err;
    logic [NS*DW-1:0] rd;
    logic [NS-1:0] exp_sel;
    idx    = int'((addr >> SEL_LSB) % (1 << SEL_W));
    mapped = idx < NS;
    exp_sel = '0;
    if (mapped) exp_sel = NS'(1 << idx);
    if (!mapped) begin
      lat = 1; exp_err = 1'b1;
    end else if (delay <= TMO) begin
      lat = delay + 1; exp_err = 1'b0;
    end else begin
      lat = TMO + 1; exp_err = 1'b1;
    end

    @(negedge clk);
    check("idle_ready", 64'(bus.ready_o), 64'd0);
    check("idle_sel", 64'(bus.sel_o), 64'd0);
    check("idle_rdata_hold", 64'(bus.rdata_o), 64'(exp_rdata));
    for (int k = 0; k < NS; k++) rd[k*DW +: DW] = (k == idx) ? data : DW'($urandom);
    bus.slave_rdata_i = rd;
    bus.req_i         = 1'b1;
    bus.addr_i        = addr;
    bus.write_i       = wr;
    bus.slave_ready_i = others(idx, hold_others, 1'b0);

    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      if (n < lat) begin
        check("wait_sel", 64'(bus.sel_o), 64'(exp_sel));
        check("wait_we", 64'(bus.we_o), 64'(wr));
        check("wait_ready", 64'(bus.ready_o), 64'd0);
        if (n == 1 && drop_req) bus.req_i = 1'b0;
        bus.slave_ready_i = others(idx, hold_others, n == delay);
      end else begin
        if (mapped && !exp_err && !wr) exp_rdata = data;
        else if (mapped && exp_err) exp_rdata = '0;
        check("resp_ready", 64'(bus.ready_o), 64'd1);
        check("resp_err", 64'(bus.err_o), 64'(exp_err));
        check("resp_rdata", 64'(bus.rdata_o), 64'(exp_rdata));
        check("resp_sel", 64'(bus.sel_o), 64'd0);
        check("resp_we", 64'(bus.we_o), 64'd0);
        bus.slave_ready_i = '0;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    bus.req_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("gap_ready", 64'(bus.ready_o), 64'd0);
      check("gap_sel", 64'(bus.sel_o), 64'd0);
      check("gap_err", 64'(bus.err_o), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] a;
    tests = 0;
    fails = 0;
    exp_rdata = '0;
    rst_n = 1'b0;
    bus.req_i = 1'b0;
    bus.addr_i = '0;
    bus.write_i = 1'b0;
    bus.slave_rdata_i = '0;
    bus.slave_ready_i = '0;
    #1;
    check("rst_ready", 64'(bus.ready_o), 64'd0);
    check("rst_err", 64'(bus.err_o), 64'd0);
    check("rst_sel", 64'(bus.sel_o), 64'd0);
    check("rst_we", 64'(bus.we_o), 64'd0);
    check("rst_rdata", 64'(bus.rdata_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read region 2, ready on first WAIT cycle
    run_txn(32'h0000_0400, 1'b0, 1, 32'hCAFE_F00D, 1'b0, 1'b0);
    // Write region 0, ready on third WAIT cycle; rdata must hold
    run_txn(32'h0000_0000, 1'b1, 3, 32'h1111_2222, 1'b0, 1'b0);
    // Unmapped index 3
    run_txn(32'h0000_0600, 1'b0, 1, 32'h3333_4444, 1'b0, 1'b0);
    // Region 1 never ready while others hold ready high -> timeout
    run_txn(32'h0000_0200, 1'b0, 99, 32'h5555_6666, 1'b1, 1'b0);
    // Ready on the last allowed WAIT cycle wins over timeout
    run_txn(32'h0000_0200, 1'b0, TMO, 32'h1234_5678, 1'b0, 1'b0);
    // Write after a read leaves captured data in place; then a write timeout clears it
    run_txn(32'h0000_0400, 1'b1, 2, 32'hDEAD_BEEF, 1'b1, 1'b0);
    run_txn(32'h0000_0400, 1'b0, 5, 32'h0BAD_F00D, 1'b0, 1'b0);
    run_txn(32'h0000_0000, 1'b1, 99, 32'h7777_8888, 1'b0, 1'b0);
    // req dropped mid-WAIT still completes
    run_txn(32'h0000_0200, 1'b0, 4, 32'h9ABC_DEF0, 1'b0, 1'b1);
    idle_cycles(1);

    // Asynchronous reset in the middle of WAIT
    run_txn(32'h0000_0000, 1'b0, 1, 32'h2468_ACE0, 1'b0, 1'b0);
    @(negedge clk);
    bus.req_i = 1'b1;
    bus.addr_i = 32'h0000_0200;
    bus.write_i = 1'b1;
    bus.slave_ready_i = '0;
    @(negedge clk);
    check("pre_rst_sel", 64'(bus.sel_o), 64'b010);
    check("pre_rst_we", 64'(bus.we_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_sel", 64'(bus.sel_o), 64'd0);
    check("arst_we", 64'(bus.we_o), 64'd0);
    check("arst_ready", 64'(bus.ready_o), 64'd0);
    check("arst_err", 64'(bus.err_o), 64'd0);
    check("arst_rdata", 64'(bus.rdata_o), 64'd0);
    exp_rdata = '0;
    bus.req_i = 1'b0;
    #2;
    rst_n = 1'b1;
    idle_cycles(3);
    run_txn(32'h0000_0200, 1'b0, 2, 32'hA5A5_1234, 1'b0, 1'b0);

    // Randomized traffic, including back-to-back requests and timeouts
    for (int t = 0; t < 60; t++) begin
      a = $urandom;
      a[SEL_LSB +: SEL_W] = SEL_W'($urandom_range(0, 3));
      run_txn(a, 1'($urandom_range(0, 1)), $urandom_range(1, TMO + 2), $urandom,
              1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
